// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and widths for the run/step/halt sequencer.
//   state_t : sequencer states (IDLE, RUN, STEP, HALTED)
//   cause_t : last stop cause reported on CAUSE
//   STATE_W / CAUSE_W : encoding widths for state and cause registers
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    NONE   = 2'd0,
    HALT   = 2'd1,
    BUDGET = 2'd2,
    STOP   = 2'd3
  } cause_t;

endpackage

// File: rtl/run_ctrl_if.sv
// -----------------------------------------------------------------------------
// run_ctrl_if
// Control/status bundle between the debug front end and the sequencer.
//   START/STOP/STEP : single-cycle command pulses
//   BUDGET          : cycle limit (0 = unlimited), captured on START
//   HALT_REQ        : core retired a halt instruction
//   CE              : core clock-enable
//   RUNNING/HALTED  : state flags
//   CAUSE           : last stop cause
//   CYCLES          : saturating count of enabled cycles
// Modports: master = front end (drives commands), slave = run_ctrl.
// -----------------------------------------------------------------------------
interface run_ctrl_if #(
  parameter int CNT_WIDTH = 32
) ();
  import run_ctrl_pkg::*;

  logic                 START;
  logic                 STOP;
  logic                 STEP;
  logic [CNT_WIDTH-1:0] BUDGET;
  logic                 HALT_REQ;
  logic                 CE;
  logic                 RUNNING;
  logic                 HALTED;
  logic [CAUSE_W-1:0]   CAUSE;
  logic [CNT_WIDTH-1:0] CYCLES;

  modport master (
    output START, STOP, STEP, BUDGET, HALT_REQ,
    input  CE, RUNNING, HALTED, CAUSE, CYCLES
  );

  modport slave (
    input  START, STOP, STEP, BUDGET, HALT_REQ,
    output CE, RUNNING, HALTED, CAUSE, CYCLES
  );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   CLOCK : clock, rising edge
//   RESET : synchronous active-high reset, clears Q
//   CLR   : synchronous clear, wins over INC
//   INC   : count enable
//   Q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic             INC,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;
  logic             w_full;

  assign w_full = &r_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_q <= '0;
    end else if (CLR) begin
      r_q <= '0;
    end else if (INC && !w_full) begin
      r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Run/step/halt sequencer producing the core clock-enable.
//   CLOCK : clock, rising edge
//   RESET : synchronous active-high reset (overrides every command)
//   bus   : run_ctrl_if.slave -- commands, BUDGET, HALT_REQ in;
//           CE, RUNNING, HALTED, CAUSE, CYCLES out
// All outputs are decoded from registers only, so a command sampled at
// edge n shows up on CE in the cycle after n.
// -----------------------------------------------------------------------------
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic     CLOCK,
  input  logic     RESET,
  run_ctrl_if.slave bus
);

  localparam logic [STATE_W-1:0] S_IDLE   = IDLE;
  localparam logic [STATE_W-1:0] S_RUN    = RUN;
  localparam logic [STATE_W-1:0] S_STEP   = STEP;
  localparam logic [STATE_W-1:0] S_HALTED = HALTED;

  localparam logic [CAUSE_W-1:0] C_NONE   = NONE;
  localparam logic [CAUSE_W-1:0] C_HALT   = HALT;
  localparam logic [CAUSE_W-1:0] C_BUDGET = BUDGET;
  localparam logic [CAUSE_W-1:0] C_STOP   = STOP;

  logic [STATE_W-1:0]   r_state,  w_state_nxt;
  logic [CAUSE_W-1:0]   r_cause,  w_cause_nxt;
  logic [CNT_WIDTH-1:0] r_budget, w_budget_nxt;

  logic                 w_ce;
  logic                 w_cnt_clr;
  logic [CNT_WIDTH-1:0] w_cycles;
  logic [CNT_WIDTH-1:0] w_cycles_inc;
  logic                 w_start_over;
  logic                 w_run_over;

  // CE is a pure state decode so it is glitch-free and registered-timed.
  assign w_ce = (r_state == S_RUN) || (r_state == S_STEP);

  // Count value after this edge, clamped at all-ones so the budget compare
  // never sees a wrapped value once the counter has saturated.
  assign w_cycles_inc = (&w_cycles) ? w_cycles
                                    : w_cycles + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // A resume whose budget is already used up must not enable a single cycle.
  assign w_start_over = (bus.BUDGET != '0) && (w_cycles >= bus.BUDGET);

  // Checked on the edge that closes a RUN cycle: that cycle is already
  // counted, so the last enabled cycle is the one that reaches the budget.
  assign w_run_over = (r_budget != '0) && (w_cycles_inc >= r_budget);

  always_comb begin
    w_state_nxt  = r_state;
    w_cause_nxt  = r_cause;
    w_budget_nxt = r_budget;
    w_cnt_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          w_budget_nxt = bus.BUDGET;
          if (w_start_over) begin
            w_state_nxt = S_HALTED;
            w_cause_nxt = C_BUDGET;
          end else begin
            w_state_nxt = S_RUN;
            w_cause_nxt = C_NONE;
          end
        end else if (bus.STEP) begin
          w_state_nxt = S_STEP;
        end
      end
      S_RUN: begin
        // HALT_REQ beats the budget, which beats STOP.
        if (bus.HALT_REQ) begin
          w_state_nxt = S_HALTED;
          w_cause_nxt = C_HALT;
        end else if (w_run_over) begin
          w_state_nxt = S_HALTED;
          w_cause_nxt = C_BUDGET;
        end else if (bus.STOP) begin
          w_state_nxt = S_IDLE;
          w_cause_nxt = C_STOP;
        end
      end
      S_STEP: begin
        // Single enabled cycle; budget deliberately not consulted here.
        if (bus.HALT_REQ) begin
          w_state_nxt = S_HALTED;
          w_cause_nxt = C_HALT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALTED: begin
        // Only START leaves HALTED, and it is a full restart from zero.
        if (bus.START) begin
          w_cnt_clr    = 1'b1;
          w_budget_nxt = bus.BUDGET;
          w_cause_nxt  = C_NONE;
          w_state_nxt  = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cause  <= C_NONE;
      r_budget <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cause  <= w_cause_nxt;
      r_budget <= w_budget_nxt;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cycles (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .CLR   (w_cnt_clr),
    .INC   (w_ce),
    .Q     (w_cycles)
  );

  assign bus.CE      = w_ce;
  assign bus.RUNNING = w_ce;
  assign bus.HALTED  = (r_state == S_HALTED);
  assign bus.CAUSE   = r_cause;
  assign bus.CYCLES  = w_cycles;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
// Two sequencers (32-bit and 4-bit counters) driven by the same commands.
// A behavioural model tracks mode, cause, cycle count and the remaining
// budget of the current run; outputs are compared to it every cycle.
// Directed sequences with literal expectations come first, then random.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0, hreq = 1'b0;
  logic [31:0] budget = '0;

  always #5 clk = ~clk;

  run_ctrl_if #(.CNT_WIDTH(32)) bus_a ();
  run_ctrl_if #(.CNT_WIDTH(4))  bus_b ();

  assign bus_a.START    = start;
  assign bus_a.STOP     = stop;
  assign bus_a.STEP     = step;
  assign bus_a.HALT_REQ = hreq;
  assign bus_a.BUDGET   = budget;
  assign bus_b.START    = start;
  assign bus_b.STOP     = stop;
  assign bus_b.STEP     = step;
  assign bus_b.HALT_REQ = hreq;
  assign bus_b.BUDGET   = budget[3:0];

  run_ctrl #(.CNT_WIDTH(32)) u_dut_a (.CLOCK(clk), .RESET(rst), .bus(bus_a));
  run_ctrl #(.CNT_WIDTH(4))  u_dut_b (.CLOCK(clk), .RESET(rst), .bus(bus_b));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 idle, 1 run, 2 step, 3 halted.
  localparam int MI = 0, MR = 1, MS = 2, MH = 3;
  int     m_mode [2];
  int     m_cause[2];
  longint m_cyc  [2];
  longint m_left [2];   // enabled cycles still allowed in this run
  bit     m_lim  [2];   // run has a nonzero budget
  longint mx     [2];

  initial begin
    mx[0] = 64'hFFFF_FFFF;
    mx[1] = 64'd15;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = MI; m_cause[k] = 0; m_cyc[k] = 0; m_left[k] = 0; m_lim[k] = 1'b0;
    end
  end

  task automatic model_edge(input int k);
    longint b, nc;
    if (rst) begin
      m_mode[k] = MI; m_cause[k] = 0; m_cyc[k] = 0; m_left[k] = 0; m_lim[k] = 1'b0;
      return;
    end
    b  = longint'(budget) & mx[k];
    nc = m_cyc[k];
    if (m_mode[k] == MR || m_mode[k] == MS)
      nc = (m_cyc[k] < mx[k]) ? m_cyc[k] + 1 : mx[k];
    case (m_mode[k])
      MI: begin
        if (start) begin
          if (b != 0 && m_cyc[k] >= b) begin
            m_mode[k] = MH; m_cause[k] = 2;
          end else begin
            m_mode[k] = MR; m_cause[k] = 0;
            m_lim[k] = (b != 0); m_left[k] = b - m_cyc[k];
          end
        end else if (step) begin
          m_mode[k] = MS;
        end
      end
      MR: begin
        if (m_lim[k]) m_left[k] = m_left[k] - 1;
        if (hreq) begin
          m_mode[k] = MH; m_cause[k] = 1;
        end else if (m_lim[k] && m_left[k] == 0) begin
          m_mode[k] = MH; m_cause[k] = 2;
        end else if (stop) begin
          m_mode[k] = MI; m_cause[k] = 3;
        end
      end
      MS: begin
        if (hreq) begin
          m_mode[k] = MH; m_cause[k] = 1;
        end else begin
          m_mode[k] = MI;
        end
      end
      default: begin
        if (start) begin
          nc = 0; m_mode[k] = MR; m_cause[k] = 0;
          m_lim[k] = (b != 0); m_left[k] = b;
        end
      end
    endcase
    m_cyc[k] = nc;
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
  end

  task automatic cmp(input int k, input logic ce, input logic run, input logic hl,
                     input logic [1:0] ca, input logic [63:0] cy);
    logic ece, ehl;
    ece = (m_mode[k] == MR) || (m_mode[k] == MS);
    ehl = (m_mode[k] == MH);
    checks++;
    if (ce !== ece || run !== ece || hl !== ehl || ca !== 2'(m_cause[k]) ||
        cy !== 64'(m_cyc[k])) begin
      failures++;
      $display("FAIL model_cmp dut%0d t=%0t got ce=%b run=%b halted=%b cause=%0d cycles=%0d required ce=%b halted=%b cause=%0d cycles=%0d",
               k, $time, ce, run, hl, ca, cy, ece, ehl, m_cause[k], m_cyc[k]);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, bus_a.CE, bus_a.RUNNING, bus_a.HALTED, bus_a.CAUSE, 64'(bus_a.CYCLES));
      cmp(1, bus_b.CE, bus_b.RUNNING, bus_b.HALTED, bus_b.CAUSE, 64'(bus_b.CYCLES));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_ce", bus_a.CE, 0);
    chk("reset_cycles", bus_a.CYCLES, 0);
    chk("reset_cause", bus_a.CAUSE, 0);
    chk("reset_halted", bus_a.HALTED, 0);

    // Free run stopped after five enabled cycles.
    start = 1'b1; budget = 0; tick(); start = 1'b0;
    chk("run_ce_latency", bus_a.CE, 1);
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_ce", bus_a.CE, 0);
    chk("stop_cycles", bus_a.CYCLES, 5);
    chk("stop_cause", bus_a.CAUSE, 3);
    chk("stop_running", bus_a.RUNNING, 0);
    chk("stop_halted", bus_a.HALTED, 0);

    // Budget of four from zero.
    do_reset();
    start = 1'b1; budget = 4; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("budget4_ce", bus_a.CE, 1);
      tick();
    end
    chk("budget4_halted", bus_a.HALTED, 1);
    chk("budget4_cause", bus_a.CAUSE, 2);
    chk("budget4_cycles", bus_a.CYCLES, 4);
    step = 1'b1; tick(); step = 1'b0;
    chk("halted_step_ce", bus_a.CE, 0);
    chk("halted_step_cycles", bus_a.CYCLES, 4);

    // HALT_REQ with STOP in the third enabled cycle.
    do_reset();
    start = 1'b1; budget = 0; tick(); start = 1'b0;
    repeat (2) tick();
    hreq = 1'b1; stop = 1'b1; tick(); hreq = 1'b0; stop = 1'b0;
    chk("halt_halted", bus_a.HALTED, 1);
    chk("halt_cause", bus_a.CAUSE, 1);
    chk("halt_cycles", bus_a.CYCLES, 3);

    // Steps from IDLE with a prior STOP cause that must survive.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk("step_ce_on", bus_a.CE, 1);
      tick();
      chk("step_ce_off", bus_a.CE, 0);
      tick();
    end
    chk("step_cycles", bus_a.CYCLES, 4);
    chk("step_cause", bus_a.CAUSE, 3);
    chk("step_running", bus_a.RUNNING, 0);

    // Budget six: pause at two, resume for four more, then restart.
    do_reset();
    start = 1'b1; budget = 6; tick(); start = 1'b0;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("pause_cycles", bus_a.CYCLES, 2);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("resume_ce", bus_a.CE, 1);
      tick();
    end
    chk("resume_halted", bus_a.HALTED, 1);
    chk("resume_cause", bus_a.CAUSE, 2);
    chk("resume_cycles", bus_a.CYCLES, 6);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_cycles", bus_a.CYCLES, 0);
    chk("restart_running", bus_a.RUNNING, 1);
    chk("restart_cause", bus_a.CAUSE, 0);
    tick();
    chk("restart_count", bus_a.CYCLES, 1);

    // Reset together with START in the middle of a run.
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk("midreset_ce", bus_a.CE, 0);
    chk("midreset_cycles", bus_a.CYCLES, 0);
    chk("midreset_cause", bus_a.CAUSE, 0);
    chk("midreset_halted", bus_a.HALTED, 0);
    tick();
    chk("midreset_idle", bus_a.CE, 0);

    // Saturation of the narrow counter.
    start = 1'b1; budget = 0; tick(); start = 1'b0;
    repeat (20) tick();
    chk("sat_cycles_w4", bus_b.CYCLES, 15);
    chk("sat_cycles_w32", bus_a.CYCLES, 20);
    stop = 1'b1; tick(); stop = 1'b0;

    // Random commands against the model.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom % 250) == 0;
      start  = ($urandom % 12) == 0;
      stop   = ($urandom % 10) == 0;
      step   = ($urandom % 10) == 0;
      hreq   = ($urandom % 15) == 0;
      budget = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; hreq = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
